// File: rtl/gb_regfile16_pkg.sv
// Shared encodings and reset defaults for the SM83 register file.
// Imported by the register-pair sub-module and by the gb_regfile16 top.
package gb_regfile_pkg;

    // 8-bit register selectors (read ports and 8-bit write)
    localparam logic [2:0] REG_B = 3'b000;
    localparam logic [2:0] REG_C = 3'b001;
    localparam logic [2:0] REG_D = 3'b010;
    localparam logic [2:0] REG_E = 3'b011;
    localparam logic [2:0] REG_H = 3'b100;
    localparam logic [2:0] REG_L = 3'b101;
    localparam logic [2:0] REG_F = 3'b110;
    localparam logic [2:0] REG_A = 3'b111;

    localparam logic [1:0] PAIR_BC = 2'b00;
    localparam logic [1:0] PAIR_DE = 2'b01;
    localparam logic [1:0] PAIR_HL = 2'b10;
    localparam logic [1:0] PAIR_SP = 2'b11;

    typedef enum logic [1:0] {
        IDU_NONE = 2'b00,
        IDU_INC  = 2'b01,
        IDU_DEC  = 2'b10,
        IDU_RSVD = 2'b11
    } idu_op_e;

    localparam logic [2:0] IDU_PC = 3'b000;
    localparam logic [2:0] IDU_SP = 3'b001;
    localparam logic [2:0] IDU_BC = 3'b010;
    localparam logic [2:0] IDU_DE = 3'b011;
    localparam logic [2:0] IDU_HL = 3'b100;

    localparam logic [2:0] ADDR_PC  = 3'b000;
    localparam logic [2:0] ADDR_SP  = 3'b001;
    localparam logic [2:0] ADDR_BC  = 3'b010;
    localparam logic [2:0] ADDR_DE  = 3'b011;
    localparam logic [2:0] ADDR_HL  = 3'b100;
    localparam logic [2:0] ADDR_FFC = 3'b101;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    localparam logic [15:0] PC_RESET_DEF = 16'h0100;
    localparam logic [15:0] SP_RESET_DEF = 16'hFFFE;
    localparam logic [15:0] AF_RESET_DEF = 16'h01B0;
    localparam logic [15:0] BC_RESET_DEF = 16'h0013;
    localparam logic [15:0] DE_RESET_DEF = 16'h00D8;
    localparam logic [15:0] HL_RESET_DEF = 16'h014D;

endpackage

// File: rtl/gb_regfile16_if.sv
// Decoder/sequencer-facing bus of the SM83 register file.
// master = sequencer side, slave = register file.
interface gb_regfile16_if #(
    parameter int ADDR_W = 16
);
    logic              wr_en;
    logic [2:0]        wr_sel;
    logic [7:0]        wr_data;
    logic [2:0]        rd_sel_a;
    logic [2:0]        rd_sel_b;
    logic [7:0]        rd_data_a;
    logic [7:0]        rd_data_b;
    logic              pair_wr_en;
    logic [1:0]        pair_sel;
    logic [ADDR_W-1:0] pair_wr_data;
    logic              flags_wr_en;
    logic [3:0]        flags_mask;
    logic [3:0]        flags_in;
    logic [1:0]        idu_op;
    logic [2:0]        idu_sel;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_data;
    logic [2:0]        addr_sel;
    logic [ADDR_W-1:0] addr_bus;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] sp_out;
    logic [7:0]        flags_out;

    modport master (
        output wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b,
               pair_wr_en, pair_sel, pair_wr_data,
               flags_wr_en, flags_mask, flags_in,
               idu_op, idu_sel, pc_load, pc_load_data, addr_sel,
        input  rd_data_a, rd_data_b, addr_bus, pc_out, sp_out, flags_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, rd_sel_a, rd_sel_b,
               pair_wr_en, pair_sel, pair_wr_data,
               flags_wr_en, flags_mask, flags_in,
               idu_op, idu_sel, pc_load, pc_load_data, addr_sel,
        output rd_data_a, rd_data_b, addr_bus, pc_out, sp_out, flags_out
    );
endinterface

// File: rtl/gb_regfile16_reg_pair.sv
// gb_reg_pair: 16-bit register with full write, IDU inc/dec and hi/lo byte writes.
// Priority: full write > IDU > byte write; o_val shows next state when BYPASS is set.
module gb_reg_pair #(
    parameter logic [15:0] RST_VAL = 16'h0000,
    parameter bit          BYPASS  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pair_wr,
    input  logic [15:0] i_pair_data,
    input  logic        i_idu_inc,
    input  logic        i_idu_dec,
    input  logic        i_hi_wr,
    input  logic        i_lo_wr,
    input  logic [7:0]  i_byte_data,
    output logic [15:0] o_val
);
    logic [15:0] r_q;
    logic [15:0] w_next;

    // Full write and IDU both cover the whole pair, so byte writes only land when both are idle.
    always_comb begin
        w_next = r_q;
        if (i_pair_wr) begin
            w_next = i_pair_data;
        end else if (i_idu_inc) begin
            w_next = r_q + 16'd1;
        end else if (i_idu_dec) begin
            w_next = r_q - 16'd1;
        end else begin
            if (i_hi_wr) w_next[15:8] = i_byte_data;
            if (i_lo_wr) w_next[7:0]  = i_byte_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= RST_VAL;
        else     r_q <= w_next;
    end

    assign o_val = BYPASS ? (rst ? RST_VAL : w_next) : r_q;
endmodule

// File: rtl/gb_regfile16.sv
// SM83 register file: dual 8-bit read, 8-bit/pair/flag writes, IDU and address-bus mux.
// Optional write-through bypass on all outputs: define GB_REGFILE_BYPASS_EN.
module gb_regfile16
    import gb_regfile_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = PC_RESET_DEF,
    parameter logic [15:0]       SP_RESET = SP_RESET_DEF,
    parameter logic [15:0]       AF_RESET = AF_RESET_DEF,
    parameter logic [15:0]       BC_RESET = BC_RESET_DEF,
    parameter logic [15:0]       DE_RESET = DE_RESET_DEF,
    parameter logic [15:0]       HL_RESET = HL_RESET_DEF
) (
    input  logic            clk,
    input  logic            rst,
    gb_regfile16_if.slave   bus
);
`ifdef GB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              w_inc, w_dec;
    logic [15:0]       w_bc, w_de, w_hl, w_sp;
    logic [7:0]        r_a, w_a_next, w_a;
    logic [3:0]        r_f, w_f_next, w_f;
    logic [ADDR_W-1:0] r_pc, w_pc_next, w_pc;

    assign w_inc = (bus.idu_op == IDU_INC);
    assign w_dec = (bus.idu_op == IDU_DEC);

    gb_reg_pair #(.RST_VAL(BC_RESET), .BYPASS(BYPASS)) u_bc (
        .clk(clk), .rst(rst),
        .i_pair_wr(bus.pair_wr_en && bus.pair_sel == PAIR_BC),
        .i_pair_data(bus.pair_wr_data),
        .i_idu_inc(w_inc && bus.idu_sel == IDU_BC),
        .i_idu_dec(w_dec && bus.idu_sel == IDU_BC),
        .i_hi_wr(bus.wr_en && bus.wr_sel == REG_B),
        .i_lo_wr(bus.wr_en && bus.wr_sel == REG_C),
        .i_byte_data(bus.wr_data),
        .o_val(w_bc)
    );

    gb_reg_pair #(.RST_VAL(DE_RESET), .BYPASS(BYPASS)) u_de (
        .clk(clk), .rst(rst),
        .i_pair_wr(bus.pair_wr_en && bus.pair_sel == PAIR_DE),
        .i_pair_data(bus.pair_wr_data),
        .i_idu_inc(w_inc && bus.idu_sel == IDU_DE),
        .i_idu_dec(w_dec && bus.idu_sel == IDU_DE),
        .i_hi_wr(bus.wr_en && bus.wr_sel == REG_D),
        .i_lo_wr(bus.wr_en && bus.wr_sel == REG_E),
        .i_byte_data(bus.wr_data),
        .o_val(w_de)
    );

    gb_reg_pair #(.RST_VAL(HL_RESET), .BYPASS(BYPASS)) u_hl (
        .clk(clk), .rst(rst),
        .i_pair_wr(bus.pair_wr_en && bus.pair_sel == PAIR_HL),
        .i_pair_data(bus.pair_wr_data),
        .i_idu_inc(w_inc && bus.idu_sel == IDU_HL),
        .i_idu_dec(w_dec && bus.idu_sel == IDU_HL),
        .i_hi_wr(bus.wr_en && bus.wr_sel == REG_H),
        .i_lo_wr(bus.wr_en && bus.wr_sel == REG_L),
        .i_byte_data(bus.wr_data),
        .o_val(w_hl)
    );

    // SP has no 8-bit write path.
    gb_reg_pair #(.RST_VAL(SP_RESET), .BYPASS(BYPASS)) u_sp (
        .clk(clk), .rst(rst),
        .i_pair_wr(bus.pair_wr_en && bus.pair_sel == PAIR_SP),
        .i_pair_data(bus.pair_wr_data),
        .i_idu_inc(w_inc && bus.idu_sel == IDU_SP),
        .i_idu_dec(w_dec && bus.idu_sel == IDU_SP),
        .i_hi_wr(1'b0),
        .i_lo_wr(1'b0),
        .i_byte_data(8'h00),
        .o_val(w_sp)
    );

    always_comb begin
        w_a_next = r_a;
        if (bus.wr_en && bus.wr_sel == REG_A) w_a_next = bus.wr_data;

        // F holds only the flag nibble; the low nibble is implied zero.
        w_f_next = r_f;
        if (bus.wr_en && bus.wr_sel == REG_F)
            w_f_next = bus.wr_data[7:4];
        else if (bus.flags_wr_en)
            w_f_next = (r_f & ~bus.flags_mask) | (bus.flags_in & bus.flags_mask);

        w_pc_next = r_pc;
        if (bus.pc_load)
            w_pc_next = bus.pc_load_data;
        else if (w_inc && bus.idu_sel == IDU_PC)
            w_pc_next = r_pc + 1'b1;
        else if (w_dec && bus.idu_sel == IDU_PC)
            w_pc_next = r_pc - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a  <= AF_RESET[15:8];
            r_f  <= AF_RESET[7:4];
            r_pc <= PC_RESET;
        end else begin
            r_a  <= w_a_next;
            r_f  <= w_f_next;
            r_pc <= w_pc_next;
        end
    end

    assign w_a  = BYPASS ? (rst ? AF_RESET[15:8] : w_a_next)  : r_a;
    assign w_f  = BYPASS ? (rst ? AF_RESET[7:4]  : w_f_next)  : r_f;
    assign w_pc = BYPASS ? (rst ? PC_RESET       : w_pc_next) : r_pc;

    function automatic logic [7:0] rd_mux(input logic [2:0] sel,
                                          input logic [15:0] bc, de, hl,
                                          input logic [7:0] a,
                                          input logic [3:0] f);
        case (sel)
            REG_B:   return bc[15:8];
            REG_C:   return bc[7:0];
            REG_D:   return de[15:8];
            REG_E:   return de[7:0];
            REG_H:   return hl[15:8];
            REG_L:   return hl[7:0];
            REG_F:   return {f, 4'b0000};
            default: return a;
        endcase
    endfunction

    assign bus.rd_data_a = rd_mux(bus.rd_sel_a, w_bc, w_de, w_hl, w_a, w_f);
    assign bus.rd_data_b = rd_mux(bus.rd_sel_b, w_bc, w_de, w_hl, w_a, w_f);

    always_comb begin
        case (bus.addr_sel)
            ADDR_SP:  bus.addr_bus = w_sp;
            ADDR_BC:  bus.addr_bus = w_bc;
            ADDR_DE:  bus.addr_bus = w_de;
            ADDR_HL:  bus.addr_bus = w_hl;
            ADDR_FFC: bus.addr_bus = {8'hFF, w_bc[7:0]};
            default:  bus.addr_bus = w_pc;
        endcase
    end

    assign bus.pc_out    = w_pc;
    assign bus.sp_out    = w_sp;
    assign bus.flags_out = {w_f, 4'b0000};
endmodule

// File: tb/tb_gb_regfile16.sv
// Directed bench for gb_regfile16; expectations follow GB_REGFILE_BYPASS_EN when defined.
module tb_gb_regfile16;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    gb_regfile16_if #(.ADDR_W(16)) bus ();

    gb_regfile16 dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.wr_en       = 1'b0;
        bus.pair_wr_en  = 1'b0;
        bus.flags_wr_en = 1'b0;
        bus.idu_op      = 2'b00;
        bus.pc_load     = 1'b0;
        #1;
    endtask

    task automatic rd(input string tag, input logic [2:0] sel, input logic [7:0] exp);
        bus.rd_sel_a = sel;
        bus.rd_sel_b = sel;
        #1;
        chk({tag, "_a"}, {8'h00, bus.rd_data_a}, {8'h00, exp});
        chk({tag, "_b"}, {8'h00, bus.rd_data_b}, {8'h00, exp});
    endtask

    task automatic addr(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        bus.addr_sel = sel;
        #1;
        chk(tag, bus.addr_bus, exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.wr_en = 0; bus.wr_sel = 0; bus.wr_data = 0;
        bus.rd_sel_a = 0; bus.rd_sel_b = 0;
        bus.pair_wr_en = 0; bus.pair_sel = 0; bus.pair_wr_data = 0;
        bus.flags_wr_en = 0; bus.flags_mask = 0; bus.flags_in = 0;
        bus.idu_op = 0; bus.idu_sel = 0;
        bus.pc_load = 0; bus.pc_load_data = 0; bus.addr_sel = 0;
        #2;
        rd("por_b", 3'b000, 8'h00);
        rd("por_c", 3'b001, 8'h13);
        rd("por_a", 3'b111, 8'h01);
        rd("por_f", 3'b110, 8'hB0);
        chk("por_pc", bus.pc_out, 16'h0100);
        chk("por_sp", bus.sp_out, 16'hFFFE);
        addr("por_addr", 3'b000, 16'h0100);
        cyc();
        rst = 1'b0;

        // B write then asynchronous reset mid-run
        bus.wr_en = 1; bus.wr_sel = 3'b000; bus.wr_data = 8'h55;
        cyc();
        rd("wr_b", 3'b000, 8'h55);
        rst = 1'b1;
        #1;
        rd("rst_b", 3'b000, 8'h00);
        rd("rst_c", 3'b001, 8'h13);
        rd("rst_a", 3'b111, 8'h01);
        rd("rst_f", 3'b110, 8'hB0);
        chk("rst_pc", bus.pc_out, 16'h0100);
        chk("rst_sp", bus.sp_out, 16'hFFFE);
        chk("rst_flags", {8'h00, bus.flags_out}, 16'h00B0);
        addr("rst_addr", 3'b000, 16'h0100);
        cyc();
        rst = 1'b0;
        cyc();

        // Pair write HL
        bus.pair_wr_en = 1; bus.pair_sel = 2'b10; bus.pair_wr_data = 16'hC000;
        cyc();
        rd("pw_h", 3'b100, 8'hC0);
        rd("pw_l", 3'b101, 8'h00);
        addr("pw_addr_hl", 3'b100, 16'hC000);

        // LD (HL+),A
        bus.idu_op = 2'b01; bus.idu_sel = 3'b100;
        bus.wr_en = 1; bus.wr_sel = 3'b111; bus.wr_data = 8'h3C;
        cyc();
        addr("idu_hl", 3'b100, 16'hC001);
        rd("idu_a", 3'b111, 8'h3C);
        rd("idu_l", 3'b101, 8'h01);

        // SP wrap both directions
        bus.pair_wr_en = 1; bus.pair_sel = 2'b11; bus.pair_wr_data = 16'h0000;
        cyc();
        chk("sp_zero", bus.sp_out, 16'h0000);
        bus.idu_op = 2'b10; bus.idu_sel = 3'b001;
        cyc();
        chk("sp_dec_wrap", bus.sp_out, 16'hFFFF);
        bus.idu_op = 2'b01; bus.idu_sel = 3'b001;
        cyc();
        chk("sp_inc_wrap", bus.sp_out, 16'h0000);

        // Collision: pair write beats IDU beats byte write
        bus.pair_wr_en = 1; bus.pair_sel = 2'b00; bus.pair_wr_data = 16'h1234;
        bus.idu_op = 2'b01; bus.idu_sel = 3'b010;
        bus.wr_en = 1; bus.wr_sel = 3'b001; bus.wr_data = 8'h99;
        cyc();
        rd("col_b", 3'b000, 8'h12);
        rd("col_c", 3'b001, 8'h34);
        bus.idu_op = 2'b01; bus.idu_sel = 3'b010;
        bus.wr_en = 1; bus.wr_sel = 3'b000; bus.wr_data = 8'hAA;
        cyc();
        addr("col_idu_bc", 3'b010, 16'h1235);

        // Flags
        bus.wr_en = 1; bus.wr_sel = 3'b110; bus.wr_data = 8'hF5;
        cyc();
        rd("f_wr", 3'b110, 8'hF0);
        bus.flags_wr_en = 1; bus.flags_mask = 4'b1010; bus.flags_in = 4'b0101;
        cyc();
        chk("f_mask", {8'h00, bus.flags_out}, 16'h0050);
        bus.flags_wr_en = 1; bus.flags_mask = 4'b1111; bus.flags_in = 4'b0000;
        bus.wr_en = 1; bus.wr_sel = 3'b110; bus.wr_data = 8'hFF;
        cyc();
        chk("f_prio", {8'h00, bus.flags_out}, 16'h00F0);

        // Reserved encodings leave state alone
        bus.idu_op = 2'b11; bus.idu_sel = 3'b000;
        cyc();
        chk("rsvd_op_pc", bus.pc_out, 16'h0100);
        bus.idu_op = 2'b01; bus.idu_sel = 3'b111;
        cyc();
        chk("rsvd_sel_pc", bus.pc_out, 16'h0100);
        addr("rsvd_sel_bc", 3'b010, 16'h1235);
        bus.idu_op = 2'b01; bus.idu_sel = 3'b000;
        cyc();
        chk("pc_inc", bus.pc_out, 16'h0101);

        // Address mux
        addr("addr_ffc", 3'b101, 16'hFF35);
        addr("addr_rsvd", 3'b110, 16'h0101);
        addr("addr_sp", 3'b001, 16'h0000);
        addr("addr_de", 3'b011, 16'h00D8);

        // pc_load beats IDU; same-cycle B write observed through read port A
        bus.pc_load = 1; bus.pc_load_data = 16'h4000;
        bus.idu_op = 2'b01; bus.idu_sel = 3'b000;
        bus.wr_en = 1; bus.wr_sel = 3'b000; bus.wr_data = 8'h77;
        bus.rd_sel_a = 3'b000;
        #1;
`ifdef GB_REGFILE_BYPASS_EN
        chk("byp_rd_a", {8'h00, bus.rd_data_a}, 16'h0077);
        chk("byp_pc", bus.pc_out, 16'h4000);
`else
        chk("byp_rd_a", {8'h00, bus.rd_data_a}, 16'h0012);
        chk("byp_pc", bus.pc_out, 16'h0101);
`endif
        cyc();
        chk("pc_load", bus.pc_out, 16'h4000);
        rd("byp_b_after", 3'b000, 8'h77);

        // PC wrap
        bus.pc_load = 1; bus.pc_load_data = 16'hFFFF;
        cyc();
        bus.idu_op = 2'b01; bus.idu_sel = 3'b000;
        cyc();
        chk("pc_wrap", bus.pc_out, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
